sr_downcount_driver: RTL and testbench
======================================

SR_DOWNCOUNT_DRIVER -- requirements
Module: sr_downcount_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of counter bits and SR stages driven (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port en, input, 1 bit: decrement request (clock tick, e.g. from the 555 astable after synchronising).
REQ-005 SHALL have port load, input, 1 bit: load request.
REQ-006 SHALL have port load_val, input, WIDTH bits: value written by a load.
REQ-007 SHALL have port q_fb, input, WIDTH bits: Q feedback from the external SR flip-flop bank.
REQ-008 SHALL have port s, output, WIDTH bits: registered set commands, one per SR stage.
REQ-009 SHALL have port r, output, WIDTH bits: registered reset commands, one per SR stage.
REQ-010 SHALL have port count, output, WIDTH bits: registered internal count value.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port borrow, output, 1 bit: one-cycle pulse on the 0 -> max wrap.
REQ-013 SHALL have port tc, output, 1 bit: combinational flag, count == 0.
REQ-014 SHALL have port err, output, 1 bit: sticky flag, feedback mismatch.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, HOLD, CHECK; transitions IDLE -> DRIVE on an accepted request, DRIVE -> HOLD, HOLD -> CHECK, CHECK -> IDLE, all unconditional except the exit from IDLE.
REQ-016 SHALL accept requests only in IDLE; en or load asserted in any other state SHALL be ignored, with no queuing.
REQ-017 SHALL give load priority when load and en are both high in IDLE: next = load_val, and en is dropped.
REQ-018 SHALL compute the next count for en alone as count-1 modulo 2^WIDTH; 0 SHALL wrap to 2^WIDTH-1.
REQ-019 SHALL, on the edge that leaves IDLE, register count <= next, s <= next & ~count(old), r <= ~next & count(old); these values are visible during DRIVE.
REQ-020 SHALL never assert s[i] and r[i] together in any cycle, including reset; bits that do not change SHALL get s=r=0.
REQ-021 SHALL drive s = 0 and r = 0 in IDLE, HOLD and CHECK.
REQ-022 SHALL assert borrow during the DRIVE cycle only, and only when en decremented count from 0.
REQ-023 SHALL keep borrow low when a load is the cause of the transition, including a load of 0 or of the maximum value.
REQ-024 SHALL compare q_fb with count while in CHECK; on a mismatch, err SHALL be set on the CHECK -> IDLE edge.
REQ-025 SHALL clear err only by reset.
REQ-026 SHALL give a request accepted at edge t: DRIVE in cycle t+1, HOLD in t+2, CHECK in t+3, IDLE in t+4, so the next request is accepted at edge t+4 at the earliest.
REQ-027 SHALL hold busy high in cycles t+1..t+3.
REQ-028 SHALL, when load_val equals count, produce a DRIVE cycle with s=r=0 and still run the full sequence, including CHECK.

Reset
REQ-029 SHALL, while reset is high, register state=IDLE, count=0, s=0, r=all ones (clearing the external bank), borrow=0, err=0.
REQ-030 SHALL give reset priority over every other input in every state; reset mid-sequence SHALL abandon the sequence with no CHECK and no err update.
REQ-031 SHALL, on the first edge after reset deasserts, return r to 0; a request present in that cycle SHALL be accepted.

Verification
REQ-032 SHALL cover: reset 2 cycles -> r=4'b1111 and s=0 during reset, then r=0, count=0, tc=1, err=0.
REQ-033 SHALL cover: load=1, load_val=4'b1010 from count=0 -> DRIVE s=4'b1010, r=0; busy for 3 cycles; count=10; borrow=0.
REQ-034 SHALL cover: en from count=0 -> count=15, s=4'b1111, r=0, borrow=1 for 1 cycle; q_fb=15 in CHECK -> err stays 0.
REQ-035 SHALL cover: en from count=8 with q_fb forced to 4'b1000 in CHECK -> s=4'b0111, r=4'b1000, count=7, err=1 and remaining 1 after further good cycles.
REQ-036 SHALL cover: load and en together in IDLE with load_val=3 -> count=3, no decrement; en pulses during DRIVE/HOLD/CHECK are ignored.
REQ-037 SHALL cover: reset asserted during HOLD -> next cycle IDLE, count=0, r=all ones, err unchanged at 0; every cycle of every test checks that s & r = 0.

Source files
------------

// File: rtl/sr_downcount_driver.sv
// sr_downcount_driver
// Down-counter that drives an external bank of SR flip-flops. Each accepted
// request (load or decrement) runs a fixed four-state sequence:
//
//   state | meaning
//   IDLE  | waiting for a request; s/r released
//   DRIVE | set/reset pulses for the changed bits are on s/r
//   HOLD  | s/r released, bank settling
//   CHECK | q_fb compared against count; mismatch sets sticky err
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous active-high reset
//   en       - decrement request (accepted only in IDLE)
//   load     - load request, wins over en (accepted only in IDLE)
//   load_val - value written by a load
//   q_fb     - Q feedback from the external SR bank
//   s, r     - registered set/reset commands, one per stage
//   count    - registered count
//   busy     - high whenever not IDLE
//   borrow   - one-cycle pulse during DRIVE on a decrement from 0
//   tc       - count == 0 (combinational)
//   err      - sticky feedback mismatch flag, cleared only by reset
module sr_downcount_driver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             borrow,
  output logic             tc,
  output logic             err
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] DRIVE = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;
  localparam logic [1:0] CHECK = 2'b11;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;
  logic             r_borrow;
  logic             r_err;

  logic [WIDTH-1:0] w_next;
  logic             w_req;

  // Load wins over en; a decrement wraps 0 -> all ones naturally.
  assign w_next = load ? load_val : (r_count - 1'b1);
  assign w_req  = load | en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_s      <= '0;
      r_r      <= '1;   // clear the external bank while in reset
      r_borrow <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // s/r/borrow are single-cycle; released unless a request is accepted.
      r_s      <= '0;
      r_r      <= '0;
      r_borrow <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state  <= DRIVE;
            r_count  <= w_next;
            // Only bits that change get a command, so s & r is always 0.
            r_s      <= w_next & ~r_count;
            r_r      <= ~w_next & r_count;
            r_borrow <= ~load & (r_count == '0);
          end
        end
        DRIVE: r_state <= HOLD;
        HOLD:  r_state <= CHECK;
        CHECK: begin
          r_state <= IDLE;
          if (q_fb != r_count) r_err <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s      = r_s;
  assign r      = r_r;
  assign count  = r_count;
  assign busy   = (r_state != IDLE);
  assign borrow = r_borrow;
  assign tc     = (r_count == '0);
  assign err    = r_err;

endmodule

// File: tb/tb_sr_downcount_driver.sv
module tb_sr_downcount_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q_fb;
  logic [3:0] s;
  logic [3:0] r;
  logic [3:0] count;
  logic       busy;
  logic       borrow;
  logic       tc;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  sr_downcount_driver #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .q_fb(q_fb), .s(s), .r(r), .count(count), .busy(busy),
    .borrow(borrow), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check_val("s_and_r_excl", s & r, 0);
  endtask

  // Expected DRIVE cycle contents.
  task automatic chk_drive(input string tag, input logic [3:0] ec, input logic [3:0] es,
                           input logic [3:0] er, input logic eb);
    check_val({tag, "_busy"}, busy, 1);
    check_val({tag, "_count"}, count, ec);
    check_val({tag, "_s"}, s, es);
    check_val({tag, "_r"}, r, er);
    check_val({tag, "_borrow"}, borrow, eb);
  endtask

  // From DRIVE: run HOLD, CHECK, IDLE with the given feedback; err expected after.
  task automatic finish_seq(input string tag, input logic [3:0] fb, input logic exp_err);
    tick();  // HOLD
    check_val({tag, "_hold_busy"}, busy, 1);
    check_val({tag, "_hold_s"}, s, 0);
    check_val({tag, "_hold_r"}, r, 0);
    check_val({tag, "_hold_borrow"}, borrow, 0);
    q_fb = fb;
    tick();  // CHECK
    check_val({tag, "_check_busy"}, busy, 1);
    tick();  // IDLE
    check_val({tag, "_idle_busy"}, busy, 0);
    check_val({tag, "_idle_err"}, err, exp_err);
  endtask

  initial begin
    reset = 1; en = 0; load = 0; load_val = 0; q_fb = 0;

    // Reset for two cycles
    tick();
    check_val("rst1_r", r, 4'hF);
    check_val("rst1_s", s, 0);
    tick();
    check_val("rst2_r", r, 4'hF);
    check_val("rst2_s", s, 0);
    check_val("rst2_busy", busy, 0);
    reset = 0;
    tick();
    check_val("post_rst_r", r, 0);
    check_val("post_rst_count", count, 0);
    check_val("post_rst_tc", tc, 1);
    check_val("post_rst_err", err, 0);

    // Load 0xA from 0
    load = 1; load_val = 4'hA;
    tick();
    load = 0;
    chk_drive("ldA", 4'hA, 4'hA, 4'h0, 0);
    check_val("ldA_tc", tc, 0);
    finish_seq("ldA", 4'hA, 0);

    // Load 0 from 0xA, then decrement from 0 (wrap)
    load = 1; load_val = 4'h0;
    tick();
    load = 0;
    chk_drive("ld0", 4'h0, 4'h0, 4'hA, 0);
    finish_seq("ld0", 4'h0, 0);
    en = 1;
    tick();
    en = 0;
    chk_drive("wrap", 4'hF, 4'hF, 4'h0, 1);
    finish_seq("wrap", 4'hF, 0);

    // Load and en together with load_val=3; en held through the sequence
    load = 1; en = 1; load_val = 4'h3;
    tick();
    load = 0;
    chk_drive("ld_en", 4'h3, 4'h0, 4'hC, 0);
    finish_seq("ld_en", 4'h3, 0);
    en = 0;
    check_val("ld_en_ign_count", count, 4'h3);

    // Load equal to count: no commands, full sequence
    load = 1; load_val = 4'h3;
    tick();
    load = 0;
    chk_drive("ld_same", 4'h3, 4'h0, 4'h0, 0);
    finish_seq("ld_same", 4'h3, 0);

    // Reset during HOLD
    load = 1; load_val = 4'h5;
    tick();
    load = 0;
    chk_drive("ld5", 4'h5, 4'h4, 4'h2, 0);
    tick();  // HOLD
    check_val("ld5_hold_busy", busy, 1);
    reset = 1;
    q_fb = 4'h9;  // would mismatch if a CHECK were reached
    tick();
    check_val("midrst_busy", busy, 0);
    check_val("midrst_count", count, 0);
    check_val("midrst_r", r, 4'hF);
    check_val("midrst_err", err, 0);
    // Request present on the first edge after reset is accepted
    reset = 0; en = 1;
    tick();
    en = 0;
    chk_drive("post_rst_req", 4'hF, 4'hF, 4'h0, 1);
    finish_seq("post_rst_req", 4'hF, 0);

    // Decrement from 8 with bad feedback
    load = 1; load_val = 4'h8;
    tick();
    load = 0;
    chk_drive("ld8", 4'h8, 4'h0, 4'h7, 0);
    finish_seq("ld8", 4'h8, 0);
    en = 1;
    tick();
    en = 0;
    chk_drive("dec8", 4'h7, 4'h7, 4'h8, 0);
    finish_seq("dec8", 4'h8, 1);

    // Good sequence afterwards: err stays sticky
    load = 1; load_val = 4'h2;
    tick();
    load = 0;
    chk_drive("ld2", 4'h2, 4'h0, 4'h5, 0);
    finish_seq("ld2", 4'h2, 1);
    tick();
    check_val("sticky_err", err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
